id_ex_pipe: RTL and testbench
=============================

// Module: id_ex_pipe
// PURPOSE
//  ID/EX pipeline register of the 5-stage MIPS pipeline. Captures the two register-file read
//  operands plus decoded control and sends them to EX. Closes the write-before-read gap of the
//  register file with a WB-to-ID bypass. Supports stall (hold), flush (bubble) and
//  refresh-while-held for stalled EX instructions.
// PARAMETERS
//  AWL  5   register address width
//  DWL  32  data width
//  CWL  4   ALU select width
// PORTS
//  CLK        in   1    pipeline clock; all state updates on posedge
//  RST        in   1    asynchronous, active-high reset
//  STALL      in   1    hold E-stage contents this cycle
//  FLUSH      in   1    load a bubble into E this cycle
//  VALID_D    in   1    ID holds a real instruction
//  RFWE_D     in   1    decoded reg-write enable
//  MEMWE_D    in   1    decoded mem-write enable
//  MEM2RF_D   in   1    writeback selects memory data
//  ALUSRC_D   in   1    ALU B selects immediate
//  REGDST_D   in   1    destination is RD (1) or RT (0)
//  ALUSEL_D   in   CWL  ALU operation
//  RS_D       in   AWL  source reg 1 address (drives RF RFRA1)
//  RT_D       in   AWL  source reg 2 address (drives RF RFRA2)
//  RD_D       in   AWL  RD field
//  RFRD1_D    in   DWL  RF read data 1
//  RFRD2_D    in   DWL  RF read data 2
//  SIMM_D     in   DWL  sign-extended immediate
//  RFWE_W     in   1    WB write enable (same signal as RF RFWE)
//  RFWA_W     in   AWL  WB write address (same signal as RF RFWA)
//  RFWD_W     in   DWL  WB write data (same signal as RF RFWD)
//  VALID_E, RFWE_E, MEMWE_E, MEM2RF_E, ALUSRC_E, REGDST_E  out  1  registered copies
//  ALUSEL_E   out  CWL  registered ALU select
//  RS_E, RT_E, RD_E         out  AWL  registered addresses
//  OPA_E, OPB_E, SIMM_E     out  DWL  registered operands / immediate
//  BUBBLE_CNT out  16   saturating count of bubbles inserted by FLUSH
// BEHAVIOUR
//  - Reset (async, RST=1): every output 0, BUBBLE_CNT=0; all outputs stay 0 until the first posedge after RST falls.
//  - Latency: 1 cycle, D inputs at posedge N appear on E outputs after edge N.
//  - Priority per edge: RST > FLUSH > STALL > load.
//  - Load: all E regs <= D inputs. Operands go through the bypass:
//      OPA = (RS_D==0) ? 0 : (RFWE_W && RFWA_W==RS_D) ? RFWD_W : RFRD1_D; OPB likewise on RT_D/RFRD2_D.
//  - Register 0 always reads 0 and is never bypassed, whatever RF holds.
//  - FLUSH: VALID_E and all control outputs <= 0; addresses, operands and SIMM_E <= 0;
//    BUBBLE_CNT += 1, saturates at 16'hFFFF. FLUSH with STALL: FLUSH wins.
//  - STALL (no FLUSH): all E regs hold, except refresh-while-held: if VALID_E && RFWE_W &&
//    RFWA_W!=0 && RFWA_W==RS_E then OPA_E <= RFWD_W; same for RT_E/OPB_E. Both may refresh on one edge.
//  - VALID_D=0 on load: the instruction is captured as a bubble (same as FLUSH), but BUBBLE_CNT does not count it.
//  - RS_D==RT_D with a matching WB write: both OPA and OPB take RFWD_W.
//  - RFWE_W with RFWA_W==0: no bypass and no refresh.
//  - Reset mid-stall: clears at once. The held instruction is lost (the upstream hazard unit must re-issue it).
//  - No combinational path from any input to any output.
// STRUCTURE
//  - Shared package mips_pkg holds AWL/DWL/CWL defaults, the ALUSEL encodings, the ZERO_REG=0
//    constant and the BUBBLE control constant (all zeros).
//  - Sub-module operand_bypass: combinational, one per operand (2 instances). Inputs: src addr, RF data, WB
//    we/addr/data. Output: the bypassed operand with the reg-0 override. The refresh path reuses the
//    same compare on the *_E address.
//  - The rest is one always block (posedge CLK, posedge RST) plus the saturating counter.
// TESTING
//  1. RST pulse mid-cycle while loaded -> every output 0 at once, before any clock edge; BUBBLE_CNT=0.
//  2. RS_D=3, RFRD1_D=0x11, RFWE_W=1, RFWA_W=3, RFWD_W=0xAA -> OPA_E=0xAA after the edge;
//     same with RFWE_W=0 -> OPA_E=0x11.
//  3. RS_D=0, RFRD1_D=0xDEAD, RFWE_W=1, RFWA_W=0, RFWD_W=5 -> OPA_E=0.
//  4. Load RT_D=7 with OPB=0x1; STALL=1 for 3 cycles; cycle 2 RFWE_W=1, RFWA_W=7, RFWD_W=0x77 ->
//     OPB_E=0x77 from cycle 2 on; all other E outputs unchanged throughout.
//  5. FLUSH=1 and STALL=1 together -> VALID_E=0, all control 0, BUBBLE_CNT +1. Force BUBBLE_CNT=0xFFFF, then FLUSH -> stays 0xFFFF.
//  6. VALID_D=0 load -> bubble on E, BUBBLE_CNT unchanged. Back-to-back loads of distinct instructions -> 1-cycle latency each.

Source files
------------

// File: rtl/mips_pkg.sv
// mips_pkg: shared widths, ALU encodings and control constants for the MIPS pipeline.
package mips_pkg;
    localparam int DEF_AWL = 5;
    localparam int DEF_DWL = 32;
    localparam int DEF_CWL = 4;
    localparam int ZERO_REG = 0;
    typedef enum logic [3:0] {
        ALU_AND = 4'd0,
        ALU_OR  = 4'd1,
        ALU_ADD = 4'd2,
        ALU_SUB = 4'd6,
        ALU_SLT = 4'd7,
        ALU_NOR = 4'd12
    } alusel_e;
    typedef struct packed {
        logic valid;
        logic rfwe;
        logic memwe;
        logic mem2rf;
        logic alusrc;
        logic regdst;
    } ctrl_t;
    localparam ctrl_t BUBBLE = '0;
    // WB write lands on src; register 0 is never a bypass target.
    function automatic logic wb_hit(input logic we, input logic [31:0] wa, input logic [31:0] src);
        return we && (wa != 32'(ZERO_REG)) && (wa == src);
    endfunction
endpackage

// File: rtl/id_ex_pipe_operand_bypass.sv
// operand_bypass: WB-to-ID forwarding of one register-file operand, register 0 reads as zero.
module operand_bypass import mips_pkg::*; #(
    parameter int AWL = DEF_AWL,
    parameter int DWL = DEF_DWL
) (
    input  logic [AWL-1:0] src,
    input  logic [DWL-1:0] rf_data,
    input  logic           we,
    input  logic [AWL-1:0] wa,
    input  logic [DWL-1:0] wd,
    output logic [DWL-1:0] op
);
    assign op = (src == AWL'(ZERO_REG)) ? '0 : wb_hit(we, 32'(wa), 32'(src)) ? wd : rf_data;
endmodule

// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register with WB bypass, stall hold with operand refresh, flush bubbles.
module id_ex_pipe import mips_pkg::*; #(
    parameter int AWL = DEF_AWL,
    parameter int DWL = DEF_DWL,
    parameter int CWL = DEF_CWL
) (
    input  logic           CLK,
    input  logic           RST,
    input  logic           STALL,
    input  logic           FLUSH,
    input  logic           VALID_D,
    input  logic           RFWE_D,
    input  logic           MEMWE_D,
    input  logic           MEM2RF_D,
    input  logic           ALUSRC_D,
    input  logic           REGDST_D,
    input  logic [CWL-1:0] ALUSEL_D,
    input  logic [AWL-1:0] RS_D,
    input  logic [AWL-1:0] RT_D,
    input  logic [AWL-1:0] RD_D,
    input  logic [DWL-1:0] RFRD1_D,
    input  logic [DWL-1:0] RFRD2_D,
    input  logic [DWL-1:0] SIMM_D,
    input  logic           RFWE_W,
    input  logic [AWL-1:0] RFWA_W,
    input  logic [DWL-1:0] RFWD_W,
    output logic           VALID_E,
    output logic           RFWE_E,
    output logic           MEMWE_E,
    output logic           MEM2RF_E,
    output logic           ALUSRC_E,
    output logic           REGDST_E,
    output logic [CWL-1:0] ALUSEL_E,
    output logic [AWL-1:0] RS_E,
    output logic [AWL-1:0] RT_E,
    output logic [AWL-1:0] RD_E,
    output logic [DWL-1:0] OPA_E,
    output logic [DWL-1:0] OPB_E,
    output logic [DWL-1:0] SIMM_E,
    output logic [15:0]    BUBBLE_CNT
);
    ctrl_t          ctrl_d, ctrl_e;
    logic [CWL-1:0] alusel_e;
    logic [AWL-1:0] rs_e, rt_e, rd_e;
    logic [DWL-1:0] opa_d, opb_d, opa_e, opb_e, simm_e;
    logic [15:0]    bubble_cnt;

    assign ctrl_d = {VALID_D, RFWE_D, MEMWE_D, MEM2RF_D, ALUSRC_D, REGDST_D};

    operand_bypass #(.AWL(AWL), .DWL(DWL)) u_byp_a (
        .src(RS_D), .rf_data(RFRD1_D), .we(RFWE_W), .wa(RFWA_W), .wd(RFWD_W), .op(opa_d)
    );
    operand_bypass #(.AWL(AWL), .DWL(DWL)) u_byp_b (
        .src(RT_D), .rf_data(RFRD2_D), .we(RFWE_W), .wa(RFWA_W), .wd(RFWD_W), .op(opb_d)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ctrl_e   <= BUBBLE;
            alusel_e <= '0;
            rs_e     <= '0;
            rt_e     <= '0;
            rd_e     <= '0;
            opa_e    <= '0;
            opb_e    <= '0;
            simm_e   <= '0;
        end else if (FLUSH || (!STALL && !VALID_D)) begin
            ctrl_e   <= BUBBLE;
            alusel_e <= '0;
            rs_e     <= '0;
            rt_e     <= '0;
            rd_e     <= '0;
            opa_e    <= '0;
            opb_e    <= '0;
            simm_e   <= '0;
        end else if (STALL) begin
            // a held instruction must still see writebacks that retire while it waits
            if (ctrl_e.valid && wb_hit(RFWE_W, 32'(RFWA_W), 32'(rs_e))) opa_e <= RFWD_W;
            if (ctrl_e.valid && wb_hit(RFWE_W, 32'(RFWA_W), 32'(rt_e))) opb_e <= RFWD_W;
        end else begin
            ctrl_e   <= ctrl_d;
            alusel_e <= ALUSEL_D;
            rs_e     <= RS_D;
            rt_e     <= RT_D;
            rd_e     <= RD_D;
            opa_e    <= opa_d;
            opb_e    <= opb_d;
            simm_e   <= SIMM_D;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) bubble_cnt <= '0;
        else if (FLUSH && bubble_cnt != 16'hFFFF) bubble_cnt <= bubble_cnt + 16'd1;
    end

    assign {VALID_E, RFWE_E, MEMWE_E, MEM2RF_E, ALUSRC_E, REGDST_E} = ctrl_e;
    assign ALUSEL_E   = alusel_e;
    assign RS_E       = rs_e;
    assign RT_E       = rt_e;
    assign RD_E       = rd_e;
    assign OPA_E      = opa_e;
    assign OPB_E      = opb_e;
    assign SIMM_E     = simm_e;
    assign BUBBLE_CNT = bubble_cnt;
endmodule

// File: tb/tb_id_ex_pipe.sv
// tb_id_ex_pipe: directed checks of bypass, stall refresh, flush/bubble counting and async reset.
module tb_id_ex_pipe;
    logic        clk = 1'b0, rst = 1'b1, stall = 1'b0, flush = 1'b0;
    logic        valid_d = 1'b0, rfwe_d = 1'b0, memwe_d = 1'b0, mem2rf_d = 1'b0, alusrc_d = 1'b0, regdst_d = 1'b0;
    logic [3:0]  alusel_d = '0;
    logic [4:0]  rs_d = '0, rt_d = '0, rd_d = '0, rfwa_w = '0;
    logic [31:0] rfrd1_d = '0, rfrd2_d = '0, simm_d = '0, rfwd_w = '0;
    logic        rfwe_w = 1'b0;
    logic        valid_e, rfwe_e, memwe_e, mem2rf_e, alusrc_e, regdst_e;
    logic [3:0]  alusel_e;
    logic [4:0]  rs_e, rt_e, rd_e;
    logic [31:0] opa_e, opb_e, simm_e;
    logic [15:0] bubble_cnt;
    int          n_chk = 0, n_fail = 0;

    id_ex_pipe dut (
        .CLK(clk), .RST(rst), .STALL(stall), .FLUSH(flush), .VALID_D(valid_d),
        .RFWE_D(rfwe_d), .MEMWE_D(memwe_d), .MEM2RF_D(mem2rf_d), .ALUSRC_D(alusrc_d), .REGDST_D(regdst_d),
        .ALUSEL_D(alusel_d), .RS_D(rs_d), .RT_D(rt_d), .RD_D(rd_d),
        .RFRD1_D(rfrd1_d), .RFRD2_D(rfrd2_d), .SIMM_D(simm_d),
        .RFWE_W(rfwe_w), .RFWA_W(rfwa_w), .RFWD_W(rfwd_w),
        .VALID_E(valid_e), .RFWE_E(rfwe_e), .MEMWE_E(memwe_e), .MEM2RF_E(mem2rf_e), .ALUSRC_E(alusrc_e),
        .REGDST_E(regdst_e), .ALUSEL_E(alusel_e), .RS_E(rs_e), .RT_E(rt_e), .RD_E(rd_e),
        .OPA_E(opa_e), .OPB_E(opb_e), .SIMM_E(simm_e), .BUBBLE_CNT(bubble_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                         input logic [31:0] d1, input logic [31:0] d2, input logic [31:0] imm);
        valid_d = v; rs_d = rs; rt_d = rt; rd_d = rd; rfrd1_d = d1; rfrd2_d = d2; simm_d = imm;
    endtask

    task automatic wb(input logic we, input logic [4:0] wa, input logic [31:0] wd);
        rfwe_w = we; rfwa_w = wa; rfwd_w = wd;
    endtask

    function automatic logic [31:0] ctrl_word();
        return {22'd0, alusel_e, valid_e, rfwe_e, memwe_e, mem2rf_e, alusrc_e, regdst_e};
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset ctrl", ctrl_word(), 32'h0);
        chk("reset opa", opa_e, 32'h0);
        chk("reset cnt", {16'd0, bubble_cnt}, 32'h0);

        // bypass hit on RS, RT reads RF
        rfwe_d = 1'b1; alusel_d = mips_pkg::ALU_ADD;
        drive(1'b1, 5'd3, 5'd4, 5'd5, 32'h11, 32'h22, 32'h1234);
        wb(1'b1, 5'd3, 32'hAA);
        step();
        chk("byp opa hit", opa_e, 32'hAA);
        chk("byp opb miss", opb_e, 32'h22);
        chk("load ctrl", ctrl_word(), {22'd0, 4'd2, 6'b110000});
        chk("load addrs", {17'd0, rs_e, rt_e, rd_e}, {17'd0, 5'd3, 5'd4, 5'd5});
        chk("load simm", simm_e, 32'h1234);
        wb(1'b0, 5'd3, 32'hAA);
        step();
        chk("no-we opa", opa_e, 32'h11);

        // register 0 reads zero and is never bypassed
        drive(1'b1, 5'd0, 5'd0, 5'd1, 32'hDEAD, 32'hBEEF, 32'h0);
        wb(1'b1, 5'd0, 32'h5);
        step();
        chk("r0 opa", opa_e, 32'h0);
        chk("r0 opb", opb_e, 32'h0);

        // stall with refresh of the held RT operand
        memwe_d = 1'b1; mem2rf_d = 1'b1; alusrc_d = 1'b1; regdst_d = 1'b1; alusel_d = mips_pkg::ALU_SUB;
        drive(1'b1, 5'd2, 5'd7, 5'd9, 32'h2, 32'h1, 32'h55);
        wb(1'b0, 5'd0, 32'h0);
        step();
        chk("stall pre opb", opb_e, 32'h1);
        stall = 1'b1;
        drive(1'b1, 5'd1, 5'd1, 5'd1, 32'hFF, 32'hFF, 32'hFF);
        alusel_d = mips_pkg::ALU_OR; rfwe_d = 1'b0;
        step();
        chk("stall c1 opb", opb_e, 32'h1);
        chk("stall c1 addrs", {17'd0, rs_e, rt_e, rd_e}, {17'd0, 5'd2, 5'd7, 5'd9});
        wb(1'b1, 5'd7, 32'h77);
        step();
        chk("stall c2 opb", opb_e, 32'h77);
        chk("stall c2 opa", opa_e, 32'h2);
        wb(1'b0, 5'd7, 32'h0);
        step();
        chk("stall c3 opb", opb_e, 32'h77);
        chk("stall c3 ctrl", ctrl_word(), {22'd0, 4'd6, 6'b111111});
        chk("stall c3 simm", simm_e, 32'h55);
        stall = 1'b0;

        // RS==RT bypass, then both operands refresh on one held edge
        drive(1'b1, 5'd6, 5'd6, 5'd2, 32'h10, 32'h10, 32'h0);
        wb(1'b1, 5'd6, 32'h66);
        step();
        chk("dual byp opa", opa_e, 32'h66);
        chk("dual byp opb", opb_e, 32'h66);
        stall = 1'b1;
        wb(1'b1, 5'd6, 32'h99);
        step();
        chk("dual ref opa", opa_e, 32'h99);
        chk("dual ref opb", opb_e, 32'h99);
        wb(1'b0, 5'd0, 32'h0);

        // flush beats stall
        flush = 1'b1;
        step();
        chk("flush ctrl", ctrl_word(), 32'h0);
        chk("flush ops", opa_e | opb_e | simm_e, 32'h0);
        chk("flush cnt", {16'd0, bubble_cnt}, 32'h1);
        flush = 1'b0; stall = 1'b0;

        // invalid instruction captured as uncounted bubble
        rfwe_d = 1'b1;
        drive(1'b0, 5'd3, 5'd4, 5'd5, 32'h33, 32'h44, 32'h66);
        step();
        chk("vd0 ctrl", ctrl_word(), 32'h0);
        chk("vd0 opa", opa_e, 32'h0);
        chk("vd0 cnt", {16'd0, bubble_cnt}, 32'h1);

        // back-to-back loads
        drive(1'b1, 5'd1, 5'd2, 5'd3, 32'h101, 32'h102, 32'h7);
        alusel_d = mips_pkg::ALU_AND;
        step();
        chk("b2b A opa", opa_e, 32'h101);
        drive(1'b1, 5'd8, 5'd9, 5'd10, 32'h202, 32'h203, 32'h8);
        alusel_d = mips_pkg::ALU_SLT;
        step();
        chk("b2b B opa", opa_e, 32'h202);
        chk("b2b B alusel", {28'd0, alusel_e}, 32'h7);

        // saturation of the bubble counter
        force dut.bubble_cnt = 16'hFFFF;
        #1 release dut.bubble_cnt;
        flush = 1'b1;
        step();
        chk("sat cnt", {16'd0, bubble_cnt}, 32'hFFFF);
        flush = 1'b0;
        step();
        chk("post-sat load", opa_e, 32'h202);

        // async reset between edges clears everything immediately
        #2 rst = 1'b1;
        #1;
        chk("areset ctrl", ctrl_word(), 32'h0);
        chk("areset ops", opa_e | opb_e | simm_e, 32'h0);
        chk("areset addrs", {17'd0, rs_e, rt_e, rd_e}, 32'h0);
        chk("areset cnt", {16'd0, bubble_cnt}, 32'h0);
        step();
        rst = 1'b0;
        step();
        chk("after reset load", opa_e, 32'h202);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
